inst_rom_ctrl: RTL and testbench
================================

Name: inst_rom_ctrl

Overview:
- Instruction-memory responder serving the core's fetch port (rom_ce / rom_addr / rom_data) from an on-chip word array.
- Adds programmable wait states and a ready/stall handshake so the pipeline can hold its PC while a fetch is outstanding.
- Provides a separate load port so a testbench or boot loader can write program words before or during execution.
- Sits beside the core top level: the fetch side connects to the core's ROM interface, and stall_req_o feeds the pipeline stall controller.

Parameters:
- ADDR_W, 10: word-address width; array depth is 2**ADDR_W 32-bit words.
- WAIT_STATES, 1: extra cycles inserted before data is returned; legal range 0..15.
- NOP_INST, 32'h0000_0000: word returned on a faulted fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_ce_i  in  1  fetch enable from the core.
- rom_addr_i  in  32  byte address of the fetch; the core holds it stable while stall_req_o=1.
- rom_data_o  out  32  fetched instruction word; valid when rom_ready_o=1.
- rom_ready_o  out  1  one-cycle pulse marking rom_data_o valid.
- stall_req_o  out  1  combinational; equals rom_ce_i & ~rom_ready_o.
- err_o  out  1  high together with rom_ready_o when the fetch faulted.
- ld_we_i  in  1  load-port write strobe.
- ld_addr_i  in  ADDR_W  load-port word address.
- ld_data_i  in  32  load-port write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rom_data_o=0, rom_ready_o=0, err_o=0.
  - Array contents are not reset.
  - Reset asserted mid-fetch aborts the fetch; no ready pulse follows deassertion.
- States:
  - IDLE:
    - If rom_ce_i=1, capture rom_addr_i and load cnt=WAIT_STATES.
    - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT:
    - cnt decrements each cycle.
    - When cnt==1, the next state is RESP.
    - If rom_ce_i drops, go to IDLE; no ready pulse is produced for the aborted fetch.
  - RESP:
    - On entry, rom_data_o and err_o are registered and rom_ready_o=1 for exactly one cycle.
    - If rom_ce_i=1 in this cycle, the new rom_addr_i is captured exactly as in IDLE (back-to-back fetch).
    - Otherwise the next state is IDLE.
- Latency and throughput:
  - Address is captured at edge N; rom_ready_o is high during cycle N+WAIT_STATES+1.
  - Sustained throughput is one word per WAIT_STATES+1 cycles.
- Output hold:
  - rom_data_o holds its last value when rom_ready_o=0.
  - rom_ready_o and err_o are 0 outside RESP.
- Address decode:
  - Word index is rom_addr_i[ADDR_W+1:2].
  - Fault if rom_addr_i[1:0]!=0 (misaligned) or rom_addr_i[31:ADDR_W+2]!=0 (out of range).
  - On a fault, rom_data_o=NOP_INST and err_o=1; the array is not read.
- Load port:
  - Writes are independent of the fetch FSM; when ld_we_i=1, mem[ld_addr_i]<=ld_data_i at the edge.
  - Write-first: if a load write and a RESP data capture hit the same word on the same edge, rom_data_o takes ld_data_i.
- Fetch disabled:
  - rom_ce_i=0 in IDLE keeps the FSM in IDLE; stall_req_o=0.

Test Plan:
1. Reset, then WAIT_STATES=0. Load mem[0]=32'h3401_1100, mem[1]=32'h3402_0020; hold ce=1 with addr 0 then 4 -> ready every cycle; data 3401_1100 then 3402_0020; stall_req_o never 1 during a ready cycle.
2. WAIT_STATES=3, single fetch of addr 8 with mem[2]=32'hDEAD_BEEF -> stall_req_o=1 for 3 cycles; ready and data DEAD_BEEF in cycle 4 after capture; err_o=0.
3. Fetch addr 32'h0000_0006 -> data 0, err_o=1. Fetch addr 32'h0001_0000 with ADDR_W=10 -> data 0, err_o=1.
4. WAIT_STATES=2: drop ce during WAIT -> no ready pulse; FSM returns to IDLE; a new fetch of addr 0 completes normally.
5. Load write mem[5]=32'h1234_5678 on the same edge that captures RESP data for addr 20 -> rom_data_o=1234_5678. A later fetch of addr 20 also returns 1234_5678.
6. Assert rst mid-WAIT -> all outputs 0 immediately. After release with ce=1, the first ready appears WAIT_STATES+1 cycles after capture.

Source files
------------

// File: rtl/inst_rom_ctrl_if.sv
// rtl/inst_rom_ctrl_if.sv - instruction fetch port between core and instruction ROM
interface inst_rom_ctrl_if;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        rom_ready_o;
    logic        stall_req_o;
    logic        err_o;

    modport master (
        output rom_ce_i, rom_addr_i,
        input  rom_data_o, rom_ready_o, stall_req_o, err_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i,
        output rom_data_o, rom_ready_o, stall_req_o, err_o
    );
endinterface

// File: rtl/inst_rom_ctrl.sv
// rtl/inst_rom_ctrl.sv - instruction ROM responder with wait states, stall request and load port
module inst_rom_ctrl #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    inst_rom_ctrl_if.slave      rom,
    input  logic                ld_we_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    input  logic [31:0]         ld_data_i
);
    localparam int          DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q;
    logic        err_q;
    logic        capture;

    logic [31:0]       mem [0:DEPTH-1];
    logic [31:0]       fetch_addr;
    logic [ADDR_W-1:0] idx;
    logic              fault;
    logic [31:0]       rd_word;

    // Next-state logic: IDLE and RESP both accept a new fetch, WAIT counts down or aborts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (rom.rom_ce_i) begin
                    capture = 1'b1;
                    addr_d  = rom.rom_addr_i;
                    cnt_d   = WS_CNT;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!rom.rom_ce_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read path: with zero wait states the address is consumed on the capture edge itself
    always_comb begin
        fetch_addr = capture ? rom.rom_addr_i : addr_q;
        idx        = fetch_addr[ADDR_W+1:2];
        fault      = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);
        if (fault) begin
            rd_word = NOP_INST;
        end else if (ld_we_i && (ld_addr_i == idx)) begin
            rd_word = ld_data_i;
        end else begin
            rd_word = mem[idx];
        end
    end

    // Fetch FSM state, counter, captured address and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= (state_d == S_RESP) ? fault : 1'b0;
            if (state_d == S_RESP) begin
                data_q <= rd_word;
            end
        end
    end

    // Load port writes run independently of the fetch FSM; array is not reset
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    assign rom.rom_data_o  = data_q;
    assign rom.rom_ready_o = (state_q == S_RESP);
    assign rom.err_o       = err_q;
    assign rom.stall_req_o = rom.rom_ce_i & ~(state_q == S_RESP);
endmodule

// File: tb/tb_inst_rom_ctrl.sv
// tb/tb_inst_rom_ctrl.sv - scoreboard bench for inst_rom_ctrl at 0, 3 and 2 wait states
module tb_inst_rom_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic [2:0]  ce_v = 3'b000;
    logic [31:0] addr_v [3];

    logic [2:0]  rdy;
    logic [2:0]  stl;
    logic [2:0]  er;
    logic [31:0] dat [3];

    int n_pass  = 0;
    int n_total = 0;
    int n_rdy [3];

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q [$];

    always #5 clk = ~clk;

    inst_rom_ctrl_if if0 ();
    inst_rom_ctrl_if if1 ();
    inst_rom_ctrl_if if2 ();

    assign if0.rom_ce_i = ce_v[0];
    assign if1.rom_ce_i = ce_v[1];
    assign if2.rom_ce_i = ce_v[2];
    assign if0.rom_addr_i = addr_v[0];
    assign if1.rom_addr_i = addr_v[1];
    assign if2.rom_addr_i = addr_v[2];
    assign rdy = {if2.rom_ready_o, if1.rom_ready_o, if0.rom_ready_o};
    assign stl = {if2.stall_req_o, if1.stall_req_o, if0.stall_req_o};
    assign er  = {if2.err_o, if1.err_o, if0.err_o};
    assign dat[0] = if0.rom_data_o;
    assign dat[1] = if1.rom_data_o;
    assign dat[2] = if2.rom_data_o;

    inst_rom_ctrl #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .rom(if0.slave),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );
    inst_rom_ctrl #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .rom(if1.slave),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );
    inst_rom_ctrl #(.ADDR_W(10), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .rom(if2.slave),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            if (rdy[s]) begin
                n_rdy[s]++;
                check("stall_on_ready", {31'd0, stl[s]}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sel", s, e.sel);
                    check("sb_data", dat[s], e.data);
                    check("sb_err", {31'd0, er[s]}, {31'd0, e.err});
                end
            end else begin
                check("err_idle", {31'd0, er[s]}, 32'd0);
                check("stall_eq_ce", {31'd0, stl[s]}, {31'd0, ce_v[s]});
            end
        end
    end

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic wait_ready(input int sel, input int ws, input string tag);
        int lat;
        int stalls;
        lat = 0;
        stalls = 0;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy[sel]) begin
                lat = i;
                break;
            end
            if (stl[sel]) stalls++;
        end
        check({tag, "_lat"}, lat, ws + 1);
        check({tag, "_stalls"}, stalls, ws);
        #1 ce_v[sel] = 1'b0;
    endtask

    task automatic fetch(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input int ws, input string tag);
        @(posedge clk);
        #1 ce_v[sel] = 1'b1; addr_v[sel] = a;
        sb_q.push_back('{sel, d, e});
        wait_ready(sel, ws, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            addr_v[s] = '0;
            n_rdy[s]  = 0;
        end

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("rst_ready", {31'd0, rdy[s]}, 32'd0);
            check("rst_err", {31'd0, er[s]}, 32'd0);
            check("rst_data", dat[s], 32'd0);
        end
        #1 rst = 1'b1;

        // 1: zero wait states, back-to-back fetches
        load(10'd0, 32'h3401_1100);
        load(10'd1, 32'h3402_0020);
        load(10'd2, 32'hDEAD_BEEF);
        load(10'd5, 32'hAAAA_5555);
        @(posedge clk);
        #1 ce_v[0] = 1'b1; addr_v[0] = 32'd0;
        sb_q.push_back('{0, 32'h3401_1100, 1'b0});
        @(posedge clk);
        #1 addr_v[0] = 32'd4;
        sb_q.push_back('{0, 32'h3402_0020, 1'b0});
        @(posedge clk);
        #1 ce_v[0] = 1'b0;
        @(negedge clk);
        #1;
        check("t1_ready_count", n_rdy[0], 2);
        check("t1_drain", sb_q.size(), 0);

        // 2: three wait states
        fetch(1, 32'd8, 32'hDEAD_BEEF, 1'b0, 3, "t2");

        // 3: misaligned and out-of-range fetches
        fetch(2, 32'h0000_0006, 32'h0, 1'b1, 2, "t3a");
        fetch(2, 32'h0001_0000, 32'h0, 1'b1, 2, "t3b");

        // 4: abort during WAIT, then a normal fetch
        @(posedge clk);
        #1 ce_v[2] = 1'b1; addr_v[2] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        #1 ce_v[2] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t4_no_ready", {31'd0, rdy[2]}, 32'd0);
        end
        fetch(2, 32'd0, 32'h3401_1100, 1'b0, 2, "t4");

        // 5: load write colliding with RESP capture of the same word
        @(posedge clk);
        #1 ce_v[0] = 1'b1; addr_v[0] = 32'd20;
        ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'h1234_5678;
        sb_q.push_back('{0, 32'h1234_5678, 1'b0});
        @(posedge clk);
        #1 ld_we = 1'b0; ce_v[0] = 1'b0;
        @(negedge clk);
        #1 check("t5_drain", sb_q.size(), 0);
        fetch(0, 32'd20, 32'h1234_5678, 1'b0, 0, "t5b");
        fetch(1, 32'd20, 32'h1234_5678, 1'b0, 3, "t5c");

        // 6: asynchronous reset mid-WAIT, then fetch after release
        @(posedge clk);
        #1 ce_v[1] = 1'b1; addr_v[1] = 32'd8;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_ready", {31'd0, rdy[1]}, 32'd0);
        check("t6_err", {31'd0, er[1]}, 32'd0);
        check("t6_data", dat[1], 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        sb_q.push_back('{1, 32'hDEAD_BEEF, 1'b0});
        wait_ready(1, 3, "t6");

        repeat (3) @(negedge clk);
        #1 check("final_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
